uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_sync.sv | 36 +++
 rtl/uart_rx_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state encoding, word-length codes and data width for UART RX
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Index of the final data bit for a given word-length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls_code);
        logic [2:0] idx;
        idx = 3'd7;
        case (wls_code)
            WLS_5:   idx = 3'd4;
            WLS_6:   idx = 3'd5;
            WLS_7:   idx = 3'd6;
            WLS_8:   idx = 3'd7;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// uart_sync : multi-flop synchroniser for the asynchronous serial line
// Revision  : 1.0
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    // Flops reset high so an idle line does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fsm.sv
// ============================================================================
// uart_rx_fsm : UART receive state machine (start/data/parity/stop, break detect)
// Optional parity support when UART_RX_PARITY_EN is defined.   Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic              rx_tick,
    output logic              tick_en,
    output logic              tick_clr,
    input  logic [1:0]        wls,
    input  logic              pen,
    input  logic              eps,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det
);

    logic rx_s;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    rx_state_e         state_q, state_d;
    logic              rx_prev_q;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        wls_q, wls_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              zero_q, zero_d;
    logic              tick_en_q, tick_en_d;
    logic              tick_clr_q, tick_clr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              break_q, break_d;
    logic              fall;

`ifdef UART_RX_PARITY_EN
    logic pen_q, pen_d, eps_q, eps_d, par_q, par_d, parity_err_q, parity_err_d;
`else
    logic unused_cfg;
    assign unused_cfg = pen ^ eps;
`endif

    // Only a genuine high-to-low transition starts a frame, so a line held
    // low after a framing error cannot retrigger until it has gone high.
    assign fall = rx_prev_q & ~rx_s;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        wls_d       = wls_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        tick_clr_d  = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;
        break_d     = break_q;
`ifdef UART_RX_PARITY_EN
        pen_d        = pen_q;
        eps_d        = eps_q;
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    tick_clr_d = 1'b1;
                    wls_d      = wls;
                    shift_d    = '0;
                    zero_d     = 1'b1;
                    bit_cnt_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
                    pen_d = pen;
                    eps_d = eps;
                    par_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    shift_d[bit_cnt_q] = rx_s;
                    zero_d             = zero_q & ~rx_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    par_d = par_q ^ rx_s;
`endif
                    if (bit_cnt_q == last_bit_idx(wls_q)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = pen_q ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (rx_tick) begin
                    par_d   = par_q ^ rx_s;
                    zero_d  = zero_q & ~rx_s;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx_tick) begin
                    rx_valid_d  = 1'b1;
                    rx_data_d   = shift_q;
                    frame_err_d = ~rx_s;
                    break_d     = zero_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
                    // par_q holds data^parity; even wants 0, odd wants 1.
                    parity_err_d = pen_q & (par_q ^ ~eps_q);
`endif
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tick_en_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rx_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            wls_q       <= WLS_8;
            shift_q     <= '0;
            zero_q      <= 1'b1;
            tick_en_q   <= 1'b0;
            tick_clr_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_s;
            bit_cnt_q   <= bit_cnt_d;
            wls_q       <= wls_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
            tick_en_q   <= tick_en_d;
            tick_clr_q  <= tick_clr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            pen_q        <= pen_d;
            eps_q        <= eps_d;
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign tick_en   = tick_en_q;
    assign tick_clr  = tick_clr_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign break_det = break_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
// ============================================================================
// tb_uart_rx_fsm : self-checking bench for uart_rx_fsm (table + random frames)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
    localparam bit PB = 1'b1;
`else
    localparam bit PB = 1'b0;
`endif
    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       rx_tick;
    logic       tick_en;
    logic       tick_clr;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       extra_tick;
    logic [3:0] tcnt;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    always #5 clk = ~clk;

    uart_rx_fsm #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_tick    (rx_tick),
        .tick_en    (tick_en),
        .tick_clr   (tick_clr),
        .wls        (wls),
        .pen        (pen),
        .eps        (eps),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det)
    );

    // Oversampling tick generator: one tick 8 clocks after a clear, then every bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    tcnt <= 4'd0;
        else if (tick_clr || !tick_en) tcnt <= 4'd0;
        else                           tcnt <= tcnt + 4'd1;
    end
    assign rx_tick = (tick_en && tcnt == 4'd7) | extra_tick;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) vcnt <= vcnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [1:0] w, input bit p, input bit e, input logic [7:0] d,
                              input bit flip, input bit stop, input bit scramble);
        logic [7:0] dn;
        logic       pbit;
        dn   = d & (8'hFF >> (3 - int'(w)));
        pbit = (e ? ^dn : ~^dn) ^ flip;
        wls = w; pen = p; eps = e;
        send_bit(1'b0);
        if (scramble) begin
            wls = 2'($urandom_range(0, 3));
            pen = 1'($urandom_range(0, 1));
            eps = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < int'(w) + 5; i++) send_bit(d[i]);
        if (p && PB) send_bit(pbit);
        send_bit(stop);
        rx_in = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    // Expected outcome from the framing rules: popcount parity, masks, all-zero break.
    task automatic model(input logic [1:0] w, input bit p, input bit e, input logic [7:0] d,
                         input bit flip, input bit stop,
                         output logic [7:0] xd, output bit xp, output bit xf, output bit xb);
        int  n, ones;
        bit  pe, pbit;
        n    = int'(w) + 5;
        xd   = 8'((32'd1 << n) - 1) & d;
        ones = $countones(xd);
        pbit = ((e ? (ones % 2) : ((ones + 1) % 2)) != 0) ^ flip;
        pe   = p && PB;
        xp   = pe && (((ones + int'(pbit)) % 2) != (e ? 0 : 1));
        xf   = !stop;
        xb   = (xd == 8'd0) && (!pe || !pbit) && !stop;
    endtask

    task automatic run_frame(input logic [1:0] w, input bit p, input bit e, input logic [7:0] d,
                             input bit flip, input bit stop, input bit scramble,
                             input logic [7:0] xd, input bit xp, input bit xf, input bit xb);
        int v0;
        v0 = vcnt;
        send_frame(w, p, e, d, flip, stop, scramble);
        check("valid_pulses", 32'(vcnt - v0), 32'd1);
        check("rx_data", 32'(rx_data), 32'(xd));
        check("parity_err", 32'(parity_err), 32'(xp));
        check("frame_err", 32'(frame_err), 32'(xf));
        check("break_det", 32'(break_det), 32'(xb));
    endtask

    typedef struct {
        logic [1:0] w;
        bit         p, e;
        logic [7:0] d;
        bit         flip, stop;
        logic [7:0] xd;
        bit         xp, xf, xb;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int         v0;
        logic [7:0] xd;
        bit         xp, xf, xb, p, e, flip, stop;
        logic [1:0] w;
        logic [7:0] d;

        tbl[0] = '{2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'd0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b1, 8'h15, PB,   1'b0, 1'b0};
        tbl[2] = '{2'd1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'd2, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{2'd3, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, !PB};

        rst_n = 1'b0; rx_in = 1'b1; wls = 2'd3; pen = 1'b0; eps = 1'b0; extra_tick = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              32'({rx_data, rx_valid, parity_err, frame_err, break_det, tick_en, tick_clr}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Ticks while idle must be ignored.
        v0 = vcnt;
        repeat (3) begin
            extra_tick = 1'b1; @(negedge clk);
            extra_tick = 1'b0; repeat (3) @(negedge clk);
        end
        check("idle_tick_valid", 32'(vcnt - v0), 32'd0);
        check("idle_tick_en", 32'(tick_en), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].w, tbl[i].p, tbl[i].e, tbl[i].d, tbl[i].flip, tbl[i].stop, 1'b1,
                      tbl[i].xd, tbl[i].xp, tbl[i].xf, tbl[i].xb);
        end

        // Short low glitch: false start, back to idle without a word.
        v0 = vcnt;
        rx_in = 1'b0; repeat (4) @(negedge clk);
        rx_in = 1'b1; repeat (4) @(negedge clk);
        check("glitch_start_tick_en", 32'(tick_en), 32'd1);
        repeat (60) @(negedge clk);
        check("glitch_valid", 32'(vcnt - v0), 32'd0);
        check("glitch_idle_tick_en", 32'(tick_en), 32'd0);

        // Line held low for three frame times: exactly one break word.
        v0 = vcnt;
        wls = 2'd3; pen = 1'b0; eps = 1'b0;
        rx_in = 1'b0; repeat (3 * 10 * BIT_CLKS) @(negedge clk);
        check("break_valid", 32'(vcnt - v0), 32'd1);
        check("break_data", 32'(rx_data), 32'd0);
        check("break_frame_err", 32'(frame_err), 32'd1);
        check("break_det", 32'(break_det), 32'd1);
        rx_in = 1'b1; repeat (40) @(negedge clk);
        check("break_release_valid", 32'(vcnt - v0), 32'd1);
        run_frame(2'd3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the data bits.
        v0 = vcnt;
        wls = 2'd3; pen = 1'b0; eps = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0; rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_outputs",
              32'({rx_data, rx_valid, parity_err, frame_err, break_det, tick_en, tick_clr}), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_valid", 32'(vcnt - v0), 32'd0);
        run_frame(2'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

        // Random frames with config inputs scrambled mid-frame.
        for (int k = 0; k < 40; k++) begin
            w    = 2'($urandom_range(0, 3));
            p    = 1'($urandom_range(0, 1));
            e    = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) d = 8'h00;
            model(w, p, e, d, flip, stop, xd, xp, xf, xb);
            run_frame(w, p, e, d, flip, stop, 1'b1, xd, xp, xf, xb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
